// File: rtl/updown_count_monitor.sv
// rtl/updown_count_monitor.sv - passive checker predicting an up/down counter's next output.
// Optional UDC_MON_FIRST_ERR_EN adds capture of the first CHECK mismatch (expected/observed).
module updown_count_monitor #(
  parameter int WIDTH          = 8,
  parameter int ERR_CNT_W      = 8,
  parameter int RESYNC_MATCHES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mon_valid,
  input  logic                 mon_rst,
  input  logic                 mon_up_dn,
  input  logic [WIDTH-1:0]     mon_data,
  output logic [WIDTH-1:0]     expected,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap_up_pulse,
`ifdef UDC_MON_FIRST_ERR_EN
  output logic                 wrap_dn_pulse,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_obs
`else
  output logic                 wrap_dn_pulse
`endif
);

  localparam int RUN_W = (RESYNC_MATCHES > 1) ? $clog2(RESYNC_MATCHES + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(RESYNC_MATCHES);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 wrap_up_q, wrap_up_d;
  logic                 wrap_dn_q, wrap_dn_d;
  // Wrap candidates remember whether the predicting sample sat at a wrap boundary.
  logic                 wup_cand_q, wup_cand_d;
  logic                 wdn_cand_q, wdn_cand_d;
  logic [WIDTH-1:0]     next_val;
  logic                 match;
`ifdef UDC_MON_FIRST_ERR_EN
  logic                 fe_valid_q, fe_valid_d;
  logic [WIDTH-1:0]     fe_exp_q, fe_exp_d;
  logic [WIDTH-1:0]     fe_obs_q, fe_obs_d;
`endif

  always_comb begin
    next_val = mon_rst ? '0 : (mon_up_dn ? mon_data + WIDTH'(1) : mon_data - WIDTH'(1));
    match    = (mon_data == exp_q);
  end

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    cnt_d       = cnt_q;
    err_pulse_d = 1'b0;
    wrap_up_d   = 1'b0;
    wrap_dn_d   = 1'b0;
    wup_cand_d  = wup_cand_q;
    wdn_cand_d  = wdn_cand_q;
`ifdef UDC_MON_FIRST_ERR_EN
    fe_valid_d  = fe_valid_q;
    fe_exp_d    = fe_exp_q;
    fe_obs_d    = fe_obs_q;
`endif
    if (!mon_valid) begin
      state_d = UNLOCKED;
      run_d   = '0;
    end else begin
      exp_d      = next_val;
      wup_cand_d = !mon_rst && mon_up_dn && (&mon_data);
      wdn_cand_d = !mon_rst && !mon_up_dn && (mon_data == '0);
      unique case (state_q)
        UNLOCKED: state_d = CHECK;
        CHECK: begin
          if (match) begin
            wrap_up_d = wup_cand_q;
            wrap_dn_d = wdn_cand_q;
          end else begin
            err_pulse_d = 1'b1;
            if (!(&cnt_q)) cnt_d = cnt_q + ERR_CNT_W'(1);
            state_d = ERROR;
            run_d   = '0;
`ifdef UDC_MON_FIRST_ERR_EN
            if (!fe_valid_q) begin
              fe_valid_d = 1'b1;
              fe_exp_d   = exp_q;
              fe_obs_d   = mon_data;
            end
`endif
          end
        end
        ERROR: begin
          if (!match) begin
            run_d = '0;
          end else if (run_q + RUN_W'(1) == RUN_TGT) begin
            run_d   = '0;
            state_d = CHECK;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      exp_q       <= '0;
      run_q       <= '0;
      cnt_q       <= '0;
      err_pulse_q <= 1'b0;
      wrap_up_q   <= 1'b0;
      wrap_dn_q   <= 1'b0;
      wup_cand_q  <= 1'b0;
      wdn_cand_q  <= 1'b0;
`ifdef UDC_MON_FIRST_ERR_EN
      fe_valid_q  <= 1'b0;
      fe_exp_q    <= '0;
      fe_obs_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      wrap_up_q   <= wrap_up_d;
      wrap_dn_q   <= wrap_dn_d;
      wup_cand_q  <= wup_cand_d;
      wdn_cand_q  <= wdn_cand_d;
`ifdef UDC_MON_FIRST_ERR_EN
      fe_valid_q  <= fe_valid_d;
      fe_exp_q    <= fe_exp_d;
      fe_obs_q    <= fe_obs_d;
`endif
    end
  end

  assign expected      = exp_q;
  assign locked        = (state_q == CHECK);
  assign err_pulse     = err_pulse_q;
  assign err_count     = cnt_q;
  assign wrap_up_pulse = wrap_up_q;
  assign wrap_dn_pulse = wrap_dn_q;
`ifdef UDC_MON_FIRST_ERR_EN
  assign first_err_valid = fe_valid_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_obs   = fe_obs_q;
`endif

endmodule

// File: tb/tb_updown_count_monitor.sv
// tb/tb_updown_count_monitor.sv - self-checking bench for updown_count_monitor.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_updown_count_monitor;
  localparam int W   = 8;
  localparam int EW  = 2;
  localparam int RM  = 2;
  localparam int MOD = 1 << W;
  localparam int SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mon_valid = 1'b0, mon_rst = 1'b0, mon_up_dn = 1'b0;
  logic [W-1:0]  mon_data = '0;
  logic [W-1:0]  expected;
  logic          locked, err_pulse, wrap_up_pulse, wrap_dn_pulse;
  logic [EW-1:0] err_count;
`ifdef UDC_MON_FIRST_ERR_EN
  logic          first_err_valid;
  logic [W-1:0]  first_err_exp, first_err_obs;
`endif

  updown_count_monitor #(.WIDTH(W), .ERR_CNT_W(EW), .RESYNC_MATCHES(RM)) dut (
    .clk(clk), .rst_n(rst_n), .mon_valid(mon_valid), .mon_rst(mon_rst),
    .mon_up_dn(mon_up_dn), .mon_data(mon_data), .expected(expected), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count), .wrap_up_pulse(wrap_up_pulse),
`ifdef UDC_MON_FIRST_ERR_EN
    .wrap_dn_pulse(wrap_dn_pulse), .first_err_valid(first_err_valid),
    .first_err_exp(first_err_exp), .first_err_obs(first_err_obs)
`else
    .wrap_dn_pulse(wrap_dn_pulse)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = no prediction available, 1 = locked, 2 = resynchronising.
  int m_mode, m_run, m_errs, m_exp, m_pr, m_pu, m_pd;
  bit m_ep, m_wu, m_wd;

  function automatic int fnext(int r, int u, int d);
    if (r != 0) return 0;
    return (u != 0) ? (d + 1) % MOD : (d + MOD - 1) % MOD;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_errs = 0; m_exp = 0;
    m_pr = 0; m_pu = 0; m_pd = 0; m_ep = 0; m_wu = 0; m_wd = 0;
  endtask

  task automatic model_step(input bit v, input bit r, input bit u, input int d);
    m_ep = 0; m_wu = 0; m_wd = 0;
    if (!v) begin
      m_mode = 0;
      m_run  = 0;
    end else begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_wu = (m_pr == 0) && (m_pu == 1) && (m_pd == MOD - 1);
          m_wd = (m_pr == 0) && (m_pu == 0) && (m_pd == 0);
        end else begin
          m_ep = 1;
          m_errs = (m_errs < SAT) ? m_errs + 1 : SAT;
          m_mode = 2;
          m_run  = 0;
        end
      end else begin
        if (d == m_exp) begin
          m_run++;
          if (m_run >= RM) begin m_mode = 1; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
      m_pr = r; m_pu = u; m_pd = d;
      m_exp = fnext(r, u, d);
    end
  endtask

  task automatic step(input bit v, input bit r, input bit u, input int d);
    mon_valid = v; mon_rst = r; mon_up_dn = u; mon_data = d[W-1:0];
    @(posedge clk);
    model_step(v, r, u, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mon_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks += 3;
    if (expected !== 8'd0) begin errors++; $display("FAIL reset_expected got=%0d want=0", expected); end
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b want=0", locked); end
    if (err_count !== '0) begin errors++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 1, i);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks += 4;
    if (expected !== 8'd0) begin errors++; $display("FAIL async_reset_expected got=%0d want=0", expected); end
    if (locked !== 1'b0) begin errors++; $display("FAIL async_reset_locked got=%b want=0", locked); end
    if (err_pulse !== 1'b0 || wrap_up_pulse !== 1'b0 || wrap_dn_pulse !== 1'b0) begin
      errors++; $display("FAIL async_reset_pulses got=%b%b%b want=000", err_pulse, wrap_up_pulse, wrap_dn_pulse);
    end
    if (err_count !== '0) begin errors++; $display("FAIL async_reset_err_count got=%0d want=0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1, 100);
    checks += 3;
    if (locked !== 1'b1) begin errors++; $display("FAIL post_reset_locked got=%b want=1", locked); end
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL post_reset_no_compare got=%b want=0", err_pulse); end
    if (expected !== 8'd101) begin errors++; $display("FAIL post_reset_expected got=%0d want=101", expected); end
  endtask

  task automatic test_count_up();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, i);
      if (i == 1) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL count_up_locked got=%b want=1", locked); end
      end
    end
    checks += 3;
    if (locked !== 1'b1) begin errors++; $display("FAIL count_up_locked_end got=%b want=1", locked); end
    if (err_count !== '0) begin errors++; $display("FAIL count_up_err_count got=%0d want=0", err_count); end
    if (expected !== 8'd6) begin errors++; $display("FAIL count_up_expected got=%0d want=6", expected); end
  endtask

  task automatic test_wrap();
    int nu, nd, ne;
    int up_seq[3] = '{254, 255, 0};
    int dn_seq[3] = '{1, 0, 255};
    do_reset();
    nu = 0; nd = 0; ne = 0;
    foreach (up_seq[i]) begin
      step(1, 0, 1, up_seq[i]);
      nu += wrap_up_pulse; nd += wrap_dn_pulse; ne += err_pulse;
    end
    checks += 2;
    if (nu != 1 || nd != 0) begin errors++; $display("FAIL wrap_up_count got=%0d/%0d want=1/0", nu, nd); end
    if (ne != 0) begin errors++; $display("FAIL wrap_up_err got=%0d want=0", ne); end
    do_reset();
    nu = 0; nd = 0; ne = 0;
    foreach (dn_seq[i]) begin
      step(1, 0, 0, dn_seq[i]);
      nu += wrap_up_pulse; nd += wrap_dn_pulse; ne += err_pulse;
    end
    step(1, 0, 0, 254);
    nu += wrap_up_pulse; nd += wrap_dn_pulse; ne += err_pulse;
    checks += 2;
    if (nd != 1 || nu != 0) begin errors++; $display("FAIL wrap_dn_count got=%0d/%0d want=1/0", nd, nu); end
    if (ne != 0) begin errors++; $display("FAIL wrap_dn_err got=%0d want=0", ne); end
  endtask

  task automatic test_error();
    do_reset();
    step(1, 0, 1, 3);
    step(1, 0, 1, 4);
    step(1, 0, 1, 7);
    checks += 3;
    if (err_pulse !== 1'b1) begin errors++; $display("FAIL err_pulse_set got=%b want=1", err_pulse); end
    if (err_count !== 2'd1) begin errors++; $display("FAIL err_count_one got=%0d want=1", err_count); end
    if (locked !== 1'b0) begin errors++; $display("FAIL err_unlocked got=%b want=0", locked); end
`ifdef UDC_MON_FIRST_ERR_EN
    checks++;
    if (first_err_valid !== 1'b1 || first_err_exp !== 8'd5 || first_err_obs !== 8'd7) begin
      errors++; $display("FAIL first_err got=%b/%0d/%0d want=1/5/7", first_err_valid, first_err_exp, first_err_obs);
    end
`endif
    step(1, 0, 1, 8);
    checks += 2;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL err_pulse_one_cycle got=%b want=0", err_pulse); end
    if (locked !== 1'b0) begin errors++; $display("FAIL resync_partial got=%b want=0", locked); end
    step(1, 0, 1, 9);
    checks += 2;
    if (locked !== 1'b1) begin errors++; $display("FAIL resync_locked got=%b want=1", locked); end
    if (err_count !== 2'd1) begin errors++; $display("FAIL resync_err_count got=%0d want=1", err_count); end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 1, 10);
      step(1, 0, 1, 11);
      step(1, 0, 1, 50);
      step(1, 0, 1, 99);
      want = (k < SAT) ? k : SAT;
      checks += 2;
      if (err_count !== want[EW-1:0]) begin errors++; $display("FAIL sat_err_count ep=%0d got=%0d want=%0d", k, err_count, want); end
      if (err_pulse !== 1'b0) begin errors++; $display("FAIL sat_error_state_pulse ep=%0d got=%b want=0", k, err_pulse); end
      step(0, 0, 1, 0);
    end
  endtask

  task automatic test_mon_rst();
    do_reset();
    step(1, 0, 1, 'h3e);
    step(1, 0, 1, 'h3f);
    step(1, 1, 1, 'h40);
    step(1, 0, 1, 'h00);
    checks += 2;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL mon_rst_err got=%b want=0", err_pulse); end
    if (locked !== 1'b1) begin errors++; $display("FAIL mon_rst_locked got=%b want=1", locked); end
    step(0, 0, 1, 'h01);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL gap_unlocked got=%b want=0", locked); end
    step(1, 0, 1, 'h77);
    checks += 3;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL gap_no_compare got=%b want=0", err_pulse); end
    if (locked !== 1'b1) begin errors++; $display("FAIL gap_relock got=%b want=1", locked); end
    if (err_count !== '0) begin errors++; $display("FAIL gap_err_count got=%0d want=0", err_count); end
  endtask

  task automatic test_random();
    bit v, r, u;
    int d;
    do_reset();
    m_pd = $urandom_range(MOD - 1);
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(99) < 93);
      r = ($urandom_range(99) < 4);
      u = ($urandom_range(99) < 60);
      d = ($urandom_range(99) < 88) ? fnext(m_pr, m_pu, m_pd) : $urandom_range(MOD - 1);
      step(v, r, u, d);
      checks += 6;
      if (expected !== m_exp[W-1:0]) begin errors++; $display("FAIL rnd_expected cyc=%0d got=%0d want=%0d", i, expected, m_exp); end
      if (locked !== (m_mode == 1)) begin errors++; $display("FAIL rnd_locked cyc=%0d got=%b want=%b", i, locked, m_mode == 1); end
      if (err_pulse !== m_ep) begin errors++; $display("FAIL rnd_err_pulse cyc=%0d got=%b want=%b", i, err_pulse, m_ep); end
      if (err_count !== m_errs[EW-1:0]) begin errors++; $display("FAIL rnd_err_count cyc=%0d got=%0d want=%0d", i, err_count, m_errs); end
      if (wrap_up_pulse !== m_wu) begin errors++; $display("FAIL rnd_wrap_up cyc=%0d got=%b want=%b", i, wrap_up_pulse, m_wu); end
      if (wrap_dn_pulse !== m_wd) begin errors++; $display("FAIL rnd_wrap_dn cyc=%0d got=%b want=%b", i, wrap_dn_pulse, m_wd); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_up();
    test_wrap();
    test_error();
    test_saturation();
    test_mon_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
